shift_deser_rx: RTL and testbench

Serial-to-parallel receive block: the far end of a serial link driven by the team's universal shift register, which is used as a parallel-in/serial-out transmitter. It shifts in one bit per enabled cycle in either bit order, assembles N-bit words, and presents each word on a registered valid/ready output with a single-entry holding register. It also reports overrun and drop conditions.

---
 rtl/shift_deser_rx_if.sv | 21 ++
 rtl/shift_deser_rx.sv | 50 +++++
 tb/tb_shift_deser_rx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/shift_deser_rx_if.sv
// shift_deser_rx_if: serial input and word-output handshake bundle for shift_deser_rx
interface shift_deser_rx_if #(parameter int N = 8);
  logic sin;
  logic sin_en;
  logic dir;
  logic abort;
  logic out_ready;
  logic clr_ovr;
  logic [N-1:0] q;
  logic q_valid;
  logic busy;
  logic overrun;
  modport master (
    output sin, sin_en, dir, abort, out_ready, clr_ovr,
    input  q, q_valid, busy, overrun
  );
  modport slave (
    input  sin, sin_en, dir, abort, out_ready, clr_ovr,
    output q, q_valid, busy, overrun
  );
endinterface

// File: rtl/shift_deser_rx.sv
// shift_deser_rx: serial-to-parallel receiver with single-entry output register and overrun flag
module shift_deser_rx #(parameter int N = 8) (
  input logic clk,
  input logic rst,
  shift_deser_rx_if.slave s
);
  localparam int CW = $clog2(N);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [N-1:0] sr, q, word;
  logic [CW-1:0] cnt;
  logic dir_l, q_valid, overrun, ord, last, done, load, drop;
  // the first bit of a word uses the live dir, later bits the latched one
  assign ord  = (cnt == '0) ? s.dir : dir_l;
  assign word = ord ? {s.sin, sr[N-1:1]} : {sr[N-2:0], s.sin};
  assign last = cnt == CW'(N - 1);
  assign done = s.sin_en & ~s.abort & last;
  assign load = done & (~q_valid | s.out_ready);
  assign drop = done & q_valid & ~s.out_ready;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      dir_l   <= 1'b0;
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (s.abort) begin
        cnt   <= '0;
        state <= IDLE;
      end else if (s.sin_en) begin
        sr    <= word;
        cnt   <= last ? '0 : cnt + CW'(1);
        state <= last ? IDLE : SHIFT;
        if (cnt == '0) dir_l <= s.dir;
      end
      if (load) begin
        q       <= word;
        q_valid <= 1'b1;
      end else if (q_valid && s.out_ready) q_valid <= 1'b0;
      overrun <= drop | (overrun & ~s.clr_ovr);
    end
  end
  assign s.q       = q;
  assign s.q_valid = q_valid;
  assign s.busy    = state == SHIFT;
  assign s.overrun = overrun;
endmodule

// File: tb/tb_shift_deser_rx.sv
// tb_shift_deser_rx: directed vector table plus hand sequences for shift_deser_rx
module tb_shift_deser_rx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int runs = 0;
  int fails = 0;
  shift_deser_rx_if #(.N(8)) sx ();
  shift_deser_rx #(.N(8)) dut (.clk(clk), .rst(rst), .s(sx));
  always #5 clk = ~clk;
  typedef struct {
    logic dir;
    logic tog;
    logic gaps;
    logic [7:0] seq;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[6];
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    runs++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic send_bits(input logic [7:0] seq, input logic tog, input logic gaps, input logic cb, input int n);
    for (int i = 0; i < n; i++) begin
      if (cb) chk("busy_mid", {31'b0, sx.busy}, {31'b0, i != 0});
      if (gaps && (i % 3 == 1)) begin
        sx.sin_en = 1'b0;
        sx.sin = ~seq[7-i];
        step();
      end
      sx.sin = seq[7-i];
      sx.sin_en = 1'b1;
      step();
      sx.sin_en = 1'b0;
      sx.dir = sx.dir ^ tog;
    end
  endtask
  task automatic consume();
    sx.out_ready = 1'b1;
    step();
    sx.out_ready = 1'b0;
  endtask
  initial begin
    logic [7:0] stream [4];
    stream[0] = 8'hA5; stream[1] = 8'h5A; stream[2] = 8'hFF; stream[3] = 8'h00;
    vt[0] = '{1'b0, 1'b0, 1'b0, 8'b10101010, 8'hAA};
    vt[1] = '{1'b1, 1'b1, 1'b0, 8'b11000000, 8'h03};
    vt[2] = '{1'b0, 1'b0, 1'b0, 8'hC3, 8'hC3};
    vt[3] = '{1'b1, 1'b0, 1'b0, 8'hA0, 8'h05};
    vt[4] = '{1'b0, 1'b0, 1'b1, 8'h3C, 8'h3C};
    vt[5] = '{1'b1, 1'b1, 1'b1, 8'h80, 8'h01};
    sx.sin = 1'b1; sx.sin_en = 1'b1; sx.dir = 1'b0; sx.abort = 1'b0;
    sx.out_ready = 1'b0; sx.clr_ovr = 1'b0;
    rst = 1'b0;
    step(); step();
    sx.sin_en = 1'b0;
    chk("rst_q", {24'b0, sx.q}, 32'h0);
    chk("rst_valid", {31'b0, sx.q_valid}, 32'h0);
    chk("rst_busy", {31'b0, sx.busy}, 32'h0);
    chk("rst_ovr", {31'b0, sx.overrun}, 32'h0);
    rst = 1'b1;
    step();
    for (int v = 0; v < 6; v++) begin
      consume();
      chk("vec_drained", {31'b0, sx.q_valid}, 32'h0);
      sx.dir = vt[v].dir;
      send_bits(vt[v].seq, vt[v].tog, vt[v].gaps, 1'b1, 8);
      chk("vec_q", {24'b0, sx.q}, {24'b0, vt[v].exp});
      chk("vec_valid", {31'b0, sx.q_valid}, 32'h1);
      chk("vec_busy_end", {31'b0, sx.busy}, 32'h0);
      chk("vec_ovr", {31'b0, sx.overrun}, 32'h0);
    end
    // abort after five bits, then a clean word
    consume();
    sx.dir = 1'b0;
    send_bits(8'hFF, 1'b0, 1'b0, 1'b0, 5);
    chk("abort_busy_pre", {31'b0, sx.busy}, 32'h1);
    sx.abort = 1'b1; sx.sin_en = 1'b1; sx.sin = 1'b1;
    step();
    sx.abort = 1'b0; sx.sin_en = 1'b0;
    chk("abort_busy_post", {31'b0, sx.busy}, 32'h0);
    chk("abort_valid", {31'b0, sx.q_valid}, 32'h0);
    send_bits(8'hC3, 1'b0, 1'b0, 1'b0, 8);
    chk("abort_q", {24'b0, sx.q}, 32'hC3);
    chk("abort_ovr", {31'b0, sx.overrun}, 32'h0);
    // overrun and clear
    consume();
    send_bits(8'h11, 1'b0, 1'b0, 1'b0, 8);
    chk("ovr_first_q", {24'b0, sx.q}, 32'h11);
    send_bits(8'h22, 1'b0, 1'b0, 1'b0, 8);
    chk("ovr_q_held", {24'b0, sx.q}, 32'h11);
    chk("ovr_valid", {31'b0, sx.q_valid}, 32'h1);
    chk("ovr_set", {31'b0, sx.overrun}, 32'h1);
    step();
    chk("ovr_sticky", {31'b0, sx.overrun}, 32'h1);
    sx.clr_ovr = 1'b1;
    step();
    sx.clr_ovr = 1'b0;
    chk("ovr_clr", {31'b0, sx.overrun}, 32'h0);
    // accept on the completing edge
    send_bits(8'h55, 1'b0, 1'b0, 1'b0, 7);
    sx.out_ready = 1'b1; sx.sin = 1'b1; sx.sin_en = 1'b1;
    step();
    sx.out_ready = 1'b0; sx.sin_en = 1'b0;
    chk("simul_q", {24'b0, sx.q}, 32'h55);
    chk("simul_valid", {31'b0, sx.q_valid}, 32'h1);
    chk("simul_ovr", {31'b0, sx.overrun}, 32'h0);
    // continuous stream with consumer always ready
    sx.out_ready = 1'b1; sx.sin_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sx.sin = stream[i/8][7 - (i % 8)];
      step();
      chk("stream_valid", {31'b0, sx.q_valid}, {31'b0, (i % 8) == 7});
      if ((i % 8) == 7) chk("stream_q", {24'b0, sx.q}, {24'b0, stream[i/8]});
    end
    sx.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sx.sin = 1'b1;
      step();
    end
    sx.sin_en = 1'b0;
    chk("pre_rst_busy", {31'b0, sx.busy}, 32'h1);
    chk("pre_rst_valid", {31'b0, sx.q_valid}, 32'h1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_busy", {31'b0, sx.busy}, 32'h0);
    chk("midrst_valid", {31'b0, sx.q_valid}, 32'h0);
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end
endmodule
